uart_frame_rx: RTL and testbench

- Receive-side packet parser for the UART control link; the counterpart of the transmit packet builder.
- Consumes the byte stream from a uart_rx byte receiver and checks framing: header 0x28 0x2A, one extra/flag byte, N records ('A' ADDR_H ADDR_L 'D' DATA_H DATA_L), then footer 0x2A 0x29.
- Emits one addr/data word per record with a valid/ready handshake, plus per-frame extra, end and error indications.
- Sits between uart_rx and the register/control fabric.

---
 rtl/uart_frame_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// UART control-link frame parser: 28 2A <extra> {'A' AH AL 'D' DH DL}* 2A 29 -> addr/data words.
// Latency: a record appears on m_addr/m_data/m_valid one clock after its DATA_L strobe.
// Backpressure: input has none; a record completed while m_valid is pending and m_ready is low is dropped (m_overflow).
//
// Ports:
//   sys_clk, sys_rst (async, active-high)
//   s_rx_data/s_rx_valid    byte stream from uart_rx (single-cycle strobe)
//   m_addr/m_data/m_valid/m_ready   record output with valid/ready handshake
//   m_extra     flag byte of the current/last frame
//   m_start, m_end, m_err, m_overflow   one-cycle event pulses
//   m_rec_cnt   records counted in the current frame (frozen at frame end)
// Optional feature: define UART_RX_TIMEOUT_EN to enable the inter-byte timeout (TIMEOUT_CYC).

module uart_frame_rx #(
    parameter int MAX_REC     = 255,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  s_rx_data,
    input  logic        s_rx_valid,
    output logic [15:0] m_addr,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_extra,
    output logic        m_start,
    output logic        m_end,
    output logic        m_err,
    output logic        m_overflow,
    output logic [7:0]  m_rec_cnt
);

    localparam logic [3:0] ST_H1  = 4'd0;
    localparam logic [3:0] ST_H2  = 4'd1;
    localparam logic [3:0] ST_EXT = 4'd2;
    localparam logic [3:0] ST_TAG = 4'd3;
    localparam logic [3:0] ST_AH  = 4'd4;
    localparam logic [3:0] ST_AL  = 4'd5;
    localparam logic [3:0] ST_DT  = 4'd6;
    localparam logic [3:0] ST_DH  = 4'd7;
    localparam logic [3:0] ST_DL  = 4'd8;
    localparam logic [3:0] ST_F2  = 4'd9;

    localparam logic [7:0] BYTE_OPEN  = 8'h28;
    localparam logic [7:0] BYTE_STAR  = 8'h2A;
    localparam logic [7:0] BYTE_CLOSE = 8'h29;
    localparam logic [7:0] BYTE_A     = 8'h41;
    localparam logic [7:0] BYTE_D     = 8'h44;
    localparam logic [7:0] MAX_REC_B  = 8'(MAX_REC);

    logic [3:0] state;
    logic [7:0] addr_h;
    logic [7:0] addr_l;
    logic [7:0] data_h;

    // On a framing error a stray 0x28 is treated as the start of a new header.
    function automatic logic [3:0] err_next(input logic [7:0] b);
        return (b == BYTE_OPEN) ? ST_H2 : ST_H1;
    endfunction

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= ST_H1;
            addr_h     <= '0;
            addr_l     <= '0;
            data_h     <= '0;
            m_addr     <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_extra    <= '0;
            m_start    <= 1'b0;
            m_end      <= 1'b0;
            m_err      <= 1'b0;
            m_overflow <= 1'b0;
            m_rec_cnt  <= '0;
`ifdef UART_RX_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            m_start    <= 1'b0;
            m_end      <= 1'b0;
            m_err      <= 1'b0;
            m_overflow <= 1'b0;

            if (m_valid && m_ready)
                m_valid <= 1'b0;

            if (s_rx_valid) begin
`ifdef UART_RX_TIMEOUT_EN
                to_cnt <= '0;
`endif
                case (state)
                    ST_H1: if (s_rx_data == BYTE_OPEN) state <= ST_H2;
                    ST_H2: begin
                        if (s_rx_data == BYTE_STAR) state <= ST_EXT;
                        else if (s_rx_data == BYTE_OPEN) state <= ST_H2;
                        else begin
                            m_err <= 1'b1;
                            state <= ST_H1;
                        end
                    end
                    ST_EXT: begin
                        m_extra   <= s_rx_data;
                        m_start   <= 1'b1;
                        m_rec_cnt <= '0;
                        state     <= ST_TAG;
                    end
                    ST_TAG: begin
                        if (s_rx_data == BYTE_A) state <= ST_AH;
                        else if (s_rx_data == BYTE_STAR) state <= ST_F2;
                        else begin
                            m_err <= 1'b1;
                            state <= err_next(s_rx_data);
                        end
                    end
                    ST_AH: begin
                        addr_h <= s_rx_data;
                        state  <= ST_AL;
                    end
                    ST_AL: begin
                        addr_l <= s_rx_data;
                        state  <= ST_DT;
                    end
                    ST_DT: begin
                        if (s_rx_data == BYTE_D) state <= ST_DH;
                        else begin
                            m_err <= 1'b1;
                            state <= err_next(s_rx_data);
                        end
                    end
                    ST_DH: begin
                        data_h <= s_rx_data;
                        state  <= ST_DL;
                    end
                    ST_DL: begin
                        // DATA_L is payload, so a record-limit error never resyncs on its value.
                        if (m_rec_cnt == MAX_REC_B) begin
                            m_err <= 1'b1;
                            state <= ST_H1;
                        end else begin
                            m_rec_cnt <= m_rec_cnt + 8'd1;
                            state     <= ST_TAG;
                            // The output slot is free if empty or being accepted this cycle.
                            if (!m_valid || m_ready) begin
                                m_addr  <= {addr_h, addr_l};
                                m_data  <= {data_h, s_rx_data};
                                m_valid <= 1'b1;
                            end else begin
                                m_overflow <= 1'b1;
                            end
                        end
                    end
                    ST_F2: begin
                        if (s_rx_data == BYTE_CLOSE) begin
                            m_end <= 1'b1;
                            state <= ST_H1;
                        end else begin
                            m_err <= 1'b1;
                            state <= err_next(s_rx_data);
                        end
                    end
                    default: state <= ST_H1;
                endcase
            end
`ifdef UART_RX_TIMEOUT_EN
            else if (state != ST_H1) begin
                // Timeout only fires on idle cycles, so it never collides with m_end.
                if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    m_err  <= 1'b1;
                    state  <= ST_H1;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  s_rx_data = 8'h00;
    logic        s_rx_valid = 1'b0;
    logic [15:0] m_addr;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_extra;
    logic        m_start;
    logic        m_end;
    logic        m_err;
    logic        m_overflow;
    logic [7:0]  m_rec_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    int err_cnt = 0;
    int end_cnt = 0;
    int ovf_cnt = 0;
    int hs_cnt  = 0;
    int e0, h0, o0, d0;

    logic [7:0] bq[$];

    uart_frame_rx #(.MAX_REC(2), .TIMEOUT_CYC(50)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid),
        .m_addr(m_addr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_extra(m_extra), .m_start(m_start), .m_end(m_end), .m_err(m_err),
        .m_overflow(m_overflow), .m_rec_cnt(m_rec_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Event counters sampled away from the active edge.
    always @(negedge sys_clk) begin
        if (m_err) err_cnt++;
        if (m_end) end_cnt++;
        if (m_overflow) ovf_cnt++;
        if (m_valid && m_ready) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was clocked in.
    task automatic send(input logic [7:0] b);
        s_rx_data  = b;
        s_rx_valid = 1'b1;
        @(negedge sys_clk);
        s_rx_valid = 1'b0;
    endtask

    task automatic send_q();
        foreach (bq[i]) send(bq[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic snap();
        e0 = err_cnt; h0 = hs_cnt; o0 = ovf_cnt; d0 = end_cnt;
    endtask

    initial begin
        idle(3);
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_addr_data", {m_addr, m_data}, 0);
        chk("rst_misc", {m_extra, m_rec_cnt, 4'd0, m_start, m_end, m_err, m_overflow}, 0);
        sys_rst = 1'b0;
        idle(2);

        // Good single-record frame, ready high.
        snap();
        bq = '{8'h28, 8'h2A, 8'h05}; send_q();
        chk("good_start", {31'd0, m_start}, 1);
        chk("good_extra", {24'd0, m_extra}, 32'h05);
        bq = '{8'h41, 8'h12, 8'h34, 8'h44, 8'hAB, 8'hCD}; send_q();
        chk("good_valid", {31'd0, m_valid}, 1);
        chk("good_word", {m_addr, m_data}, 32'h1234ABCD);
        bq = '{8'h2A, 8'h29}; send_q();
        chk("good_end", {31'd0, m_end}, 1);
        chk("good_cnt", {24'd0, m_rec_cnt}, 1);
        idle(2);
        chk("good_noerr", err_cnt - e0, 0);
        chk("good_hs", hs_cnt - h0, 1);

        // Two records with ready low: second is dropped.
        m_ready = 1'b0;
        snap();
        bq = '{8'h28, 8'h2A, 8'h01, 8'h41, 8'h00, 8'h10, 8'h44, 8'h00, 8'h20,
               8'h41, 8'h00, 8'h11, 8'h44, 8'h00}; send_q();
        chk("ovf_before", ovf_cnt - o0, 0);
        send(8'h21);
        chk("ovf_pulse", {31'd0, m_overflow}, 1);
        chk("ovf_kept", {m_addr, m_data}, 32'h00100020);
        chk("ovf_cnt", {24'd0, m_rec_cnt}, 2);
        bq = '{8'h2A, 8'h29}; send_q();
        chk("ovf_end", {31'd0, m_end}, 1);
        chk("ovf_still_valid", {31'd0, m_valid}, 1);
        m_ready = 1'b1;
        idle(1);
        chk("ovf_drained", {31'd0, m_valid}, 0);
        idle(1);
        chk("ovf_once", ovf_cnt - o0, 1);

        // Tag values inside payload.
        snap();
        bq = '{8'h28, 8'h2A, 8'h2A}; send_q();
        chk("pay_extra", {24'd0, m_extra}, 32'h2A);
        bq = '{8'h41, 8'h2A, 8'h28, 8'h44, 8'h29, 8'h2A}; send_q();
        chk("pay_word", {m_addr, m_data}, 32'h2A28292A);
        chk("pay_valid", {31'd0, m_valid}, 1);
        bq = '{8'h2A, 8'h29}; send_q();
        chk("pay_end", {31'd0, m_end}, 1);
        idle(2);
        chk("pay_noerr", err_cnt - e0, 0);

        // Bad tag, then a good frame.
        snap();
        bq = '{8'h28, 8'h2A, 8'h00, 8'h41, 8'h00, 8'h01, 8'h55}; send_q();
        chk("bad_err", {31'd0, m_err}, 1);
        chk("bad_novalid", {31'd0, m_valid}, 0);
        bq = '{8'h28, 8'h2A, 8'h03, 8'h41, 8'hBE, 8'hEF, 8'h44, 8'hCA, 8'hFE}; send_q();
        chk("bad_next_word", {m_addr, m_data}, 32'hBEEFCAFE);
        bq = '{8'h2A, 8'h29}; send_q();
        chk("bad_next_end", {31'd0, m_end}, 1);
        idle(2);
        chk("bad_err_once", err_cnt - e0, 1);
        chk("bad_hs", hs_cnt - h0, 1);

        // Resync on 0x28 where a tag was expected.
        snap();
        bq = '{8'h28, 8'h2A, 8'h00, 8'h28}; send_q();
        chk("sync_err", {31'd0, m_err}, 1);
        bq = '{8'h2A, 8'h07}; send_q();
        chk("sync_start", {31'd0, m_start}, 1);
        chk("sync_extra", {24'd0, m_extra}, 32'h07);
        bq = '{8'h2A, 8'h29}; send_q();
        chk("sync_end", {31'd0, m_end}, 1);
        chk("sync_cnt", {24'd0, m_rec_cnt}, 0);

        // Record limit (MAX_REC=2): the third record is an error, not output.
        idle(1);
        snap();
        bq = '{8'h28, 8'h2A, 8'h0C,
               8'h41, 8'h00, 8'h01, 8'h44, 8'h00, 8'h01,
               8'h41, 8'h00, 8'h02, 8'h44, 8'h00, 8'h02,
               8'h41, 8'h00, 8'h03, 8'h44, 8'h00, 8'h03}; send_q();
        chk("max_err", {31'd0, m_err}, 1);
        chk("max_cnt", {24'd0, m_rec_cnt}, 2);
        chk("max_novalid", {31'd0, m_valid}, 0);
        idle(2);
        chk("max_hs", hs_cnt - h0, 2);

        // Reset mid-record with a pending record.
        m_ready = 1'b0;
        bq = '{8'h28, 8'h2A, 8'h09, 8'h41, 8'h11, 8'h22, 8'h44, 8'h33, 8'h44,
               8'h41, 8'h55, 8'h66}; send_q();
        chk("rst_pending", {31'd0, m_valid}, 1);
        sys_rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, m_valid}, 0);
        chk("rst_async_regs", {m_addr, m_data}, 0);
        chk("rst_async_misc", {m_extra, m_rec_cnt, 16'd0}, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        m_ready = 1'b1;
        idle(1);
        bq = '{8'h28, 8'h2A, 8'h0A, 8'h41, 8'h00, 8'h01, 8'h44, 8'h00, 8'h02}; send_q();
        chk("post_rst_word", {m_addr, m_data}, 32'h00010002);
        bq = '{8'h2A, 8'h29}; send_q();
        chk("post_rst_end", {31'd0, m_end}, 1);
        chk("post_rst_ctx", {16'd0, m_extra, m_rec_cnt}, 32'h0A01);

`ifdef UART_RX_TIMEOUT_EN
        idle(1);
        snap();
        bq = '{8'h28, 8'h2A, 8'h00, 8'h41}; send_q();
        idle(60);
        chk("to_err", err_cnt - e0, 1);
        bq = '{8'h28, 8'h2A, 8'h05}; send_q();
        chk("to_restart", {31'd0, m_start}, 1);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
